// File: rtl/reg_bank_pkg.sv
// Shared register-bank types and architectural register numbers.
package reg_bank_pkg;
    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP   = 5'd29;
    localparam reg_addr_t REG_RA   = 5'd31;
    localparam int        NUM_REGS = 32;
endpackage

// File: rtl/reg_bank_fwd.sv
// Per-port read select: hardwired zero, then the staged write, then the array.
// Zero latency (pure combinational); no backpressure.
// Address 0 is tested first so a staged write to r0 can never leak out.
module reg_bank_fwd
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  reg_addr_t         rd_addr,
    input  logic              stage_vld,
    input  reg_addr_t         stage_addr,
    input  logic [DATA_W-1:0] stage_data,
    input  logic [DATA_W-1:0] arr_data,
    output logic [DATA_W-1:0] rd_data
);
    always_comb begin
        rd_data = arr_data;
        if (rd_addr == REG_ZERO) begin
            rd_data = '0;
        end else if (stage_vld && (stage_addr == rd_addr)) begin
            rd_data = stage_data;
        end
    end
endmodule

// File: rtl/reg_bank.sv
// 32-entry register file with a one-deep write staging register and forwarding.
// Writes are visible to reads right after the capture edge and reach the array one edge later.
// No backpressure: a write is accepted on every edge with wr_en high.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h0000_00E3)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  reg_addr_t         wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  reg_addr_t         rd_addr_a,
    input  reg_addr_t         rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              wr_pending
);
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              stage_vld;
    reg_addr_t         stage_addr;
    logic [DATA_W-1:0] stage_data;

    // Array and stage-valid share the reset; clearing stage_vld drops an in-flight write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_vld <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (reg_addr_t'(i) == REG_SP) ? SP_INIT : '0;
            end
        end else begin
            stage_vld <= wr_en;
            if (stage_vld && (stage_addr != REG_ZERO)) begin
                regs[stage_addr] <= stage_data;
            end
        end
    end

    // Staged address/data are qualified by stage_vld, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stage_addr <= wr_addr;
            stage_data <= wr_data;
        end
    end

    assign wr_pending = stage_vld && (stage_addr != REG_ZERO);

    reg_bank_fwd #(.DATA_W(DATA_W)) u_fwd_a (
        .rd_addr    (rd_addr_a),
        .stage_vld  (stage_vld),
        .stage_addr (stage_addr),
        .stage_data (stage_data),
        .arr_data   (regs[rd_addr_a]),
        .rd_data    (rd_data_a)
    );

    reg_bank_fwd #(.DATA_W(DATA_W)) u_fwd_b (
        .rd_addr    (rd_addr_b),
        .stage_vld  (stage_vld),
        .stage_addr (stage_addr),
        .stage_data (stage_data),
        .arr_data   (regs[rd_addr_b]),
        .rd_data    (rd_data_b)
    );
endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: directed scenarios plus random traffic against a visible-value model.
module tb_reg_bank;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        wr_pending;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: what each register reads as, and whether a nonzero write is outstanding.
    logic [31:0] vis [32];
    bit          pend;

    reg_bank dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .wr_pending (wr_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) vis[i] = (i == 29) ? 32'h0000_00E3 : 32'h0;
        pend = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : vis[a];
    endfunction

    // Advance one edge; the model applies the write that edge captures, outputs settle #1 later.
    task automatic tick();
        @(posedge clk);
        if (reset_n) begin
            if (wr_en && wr_addr != 5'd0) vis[wr_addr] = wr_data;
            pend = wr_en && (wr_addr != 5'd0);
        end else begin
            model_reset();
        end
        #1;
    endtask

    task automatic drive(input logic en, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb);
        wr_en = en; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 32; i++) begin
            logic [31:0] exp_a, exp_b;
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            exp_a = (i == 29) ? 32'h0000_00E3 : 32'h0;
            exp_b = (31 - i == 29) ? 32'h0000_00E3 : 32'h0;
            n_tests++;
            if (rd_data_a !== exp_a) begin
                n_fail++; $display("FAIL reset_rd_a[%0d]: got %h want %h", i, rd_data_a, exp_a);
            end
            n_tests++;
            if (rd_data_b !== exp_b) begin
                n_fail++; $display("FAIL reset_rd_b[%0d]: got %h want %h", 31 - i, rd_data_b, exp_b);
            end
        end
        n_tests++;
        if (wr_pending !== 1'b0) begin
            n_fail++; $display("FAIL reset_pending: got %b want 0", wr_pending);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_forward();
        drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd5);
        #1;
        n_tests++;
        if (rd_data_a !== 32'h0) begin
            n_fail++; $display("FAIL fwd_pre_edge: got %h want 00000000", rd_data_a);
        end
        tick();
        wr_en = 1'b0;
        n_tests++;
        if (rd_data_a !== 32'hDEAD_BEEF || wr_pending !== 1'b1) begin
            n_fail++; $display("FAIL fwd_staged: got %h/%b want deadbeef/1", rd_data_a, wr_pending);
        end
        tick();
        n_tests++;
        if (rd_data_a !== 32'hDEAD_BEEF || wr_pending !== 1'b0) begin
            n_fail++; $display("FAIL fwd_committed: got %h/%b want deadbeef/0", rd_data_a, wr_pending);
        end
        tick();
        n_tests++;
        if (rd_data_a !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL fwd_held: got %h want deadbeef", rd_data_a);
        end
    endtask

    task automatic test_zero_write();
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            wr_en = 1'b0;
            n_tests++;
            if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0 || wr_pending !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_write[%0d]: got a=%h b=%h pend=%b want 0/0/0",
                         c, rd_data_a, rd_data_b, wr_pending);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd31, 32'd1, 5'd31, 5'd31);
        tick();
        n_tests++;
        if (rd_data_a !== 32'd1) begin
            n_fail++; $display("FAIL b2b_first: got %h want 00000001", rd_data_a);
        end
        wr_data = 32'd2;
        tick();
        wr_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (rd_data_a !== 32'd2 || rd_data_b !== 32'd2) begin
                n_fail++; $display("FAIL b2b_second[%0d]: got a=%h b=%h want 2", c, rd_data_a, rd_data_b);
            end
            tick();
        end
    endtask

    task automatic test_reset_discard();
        drive(1'b1, 5'd9, 32'h1234_5678, 5'd9, 5'd29);
        tick();
        wr_en = 1'b0;
        n_tests++;
        if (rd_data_a !== 32'h1234_5678 || wr_pending !== 1'b1) begin
            n_fail++; $display("FAIL discard_staged: got %h/%b want 12345678/1", rd_data_a, wr_pending);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (rd_data_a !== 32'h0 || wr_pending !== 1'b0 || rd_data_b !== 32'h0000_00E3) begin
            n_fail++;
            $display("FAIL discard_async: got a=%h b=%h pend=%b want 0/e3/0", rd_data_a, rd_data_b, wr_pending);
        end
        tick();
        reset_n = 1'b1;
        tick();
        n_tests++;
        if (rd_data_a !== 32'h0 || wr_pending !== 1'b0) begin
            n_fail++; $display("FAIL discard_after: got %h/%b want 0/0", rd_data_a, wr_pending);
        end
        drive(1'b1, 5'd9, 32'h0000_A5A5, 5'd9, 5'd9);
        tick();
        wr_en = 1'b0;
        n_tests++;
        if (rd_data_a !== 32'h0000_A5A5 || wr_pending !== 1'b1) begin
            n_fail++; $display("FAIL first_capture: got %h/%b want 0000a5a5/1", rd_data_a, wr_pending);
        end
        tick();
    endtask

    task automatic test_ports();
        logic [31:0] a_before;
        a_before = model_read(5'd9);
        drive(1'b1, 5'd10, 32'd7, 5'd9, 5'd10);
        #1;
        n_tests++;
        if (rd_data_b !== model_read(5'd10)) begin
            n_fail++; $display("FAIL ports_pre_edge: got %h want %h", rd_data_b, model_read(5'd10));
        end
        tick();
        wr_en = 1'b0;
        n_tests++;
        if (rd_data_a !== a_before || rd_data_b !== 32'd7) begin
            n_fail++; $display("FAIL ports_split: got a=%h b=%h want %h/7", rd_data_a, rd_data_b, a_before);
        end
        tick();
    endtask

    task automatic test_random();
        logic [4:0] last_wa = 5'd1;
        for (int c = 0; c < 400; c++) begin
            logic [4:0] wa, ra, rb;
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 2) == 0) ? last_wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wa, $urandom, ra, rb);
            #1;
            n_tests++;
            if (rd_data_a !== model_read(ra) || rd_data_b !== model_read(rb) || wr_pending !== pend) begin
                n_fail++;
                $display("FAIL rand_pre[%0d]: got a=%h b=%h p=%b want %h/%h/%b",
                         c, rd_data_a, rd_data_b, wr_pending, model_read(ra), model_read(rb), pend);
            end
            if (wr_en) last_wa = wa;
            tick();
            n_tests++;
            if (rd_data_a !== model_read(ra) || rd_data_b !== model_read(rb) || wr_pending !== pend) begin
                n_fail++;
                $display("FAIL rand_post[%0d]: got a=%h b=%h p=%b want %h/%h/%b",
                         c, rd_data_a, rd_data_b, wr_pending, model_read(ra), model_read(rb), pend);
            end
        end
        wr_en = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            #1;
            n_tests++;
            if (rd_data_a !== model_read(5'(i))) begin
                n_fail++; $display("FAIL rand_final[%0d]: got %h want %h", i, rd_data_a, model_read(5'(i)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_zero_write();
        test_back_to_back();
        test_reset_discard();
        test_ports();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter SP_INIT, default 32'h0000_00E3, reset value of register 29 ($sp).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_en  input  1  write request, sampled on the rising edge.
REQ-006 wr_addr  input  5  destination register; driven by the 8-way 5-bit destination-select mux.
REQ-007 wr_data  input  DATA_W  write data.
REQ-008 rd_addr_a / rd_addr_b  input  5 each  read port A/B addresses (rs/rt).
REQ-009 rd_data_a / rd_data_b  output  DATA_W each  read port A/B data, combinational.
REQ-010 wr_pending  output  1  high while a write is staged and not yet committed.

Function
REQ-011 Storage: 32 registers of DATA_W bits; register 0 reads as 0 always.
REQ-012 Two-stage write: an edge with wr_en=1 captures {wr_addr, wr_data} into a staging register (stage valid=1); the following edge commits the staged value to the array.
REQ-013 Stage valid is set on any edge with wr_en=1; cleared on an edge with wr_en=0; back-to-back writes commit the old stage and capture the new one on the same edge.
REQ-014 A write with wr_addr=0 is captured normally but never commits; forwarding never applies to address 0.
REQ-015 wr_pending equals stage valid and is 0 whenever the staged address is 0.
REQ-016 Read priority, per port: address 0 -> 0; else staged valid and address match -> staged data; else array contents.
REQ-017 Read latency: zero cycles; a value written with wr_en at edge N is visible on reads from just after edge N.
REQ-018 Simultaneous write-to-stage and read of the same address in the cycle before the edge returns the pre-edge value (no combinational wr_data bypass).
REQ-019 Two consecutive writes to the same address: the later write's data wins on reads and in the array after both commits.
REQ-020 Port A and port B are independent; identical addresses return identical data.

Reset
REQ-021 reset_n low asynchronously clears all registers to 0 except register 29 = SP_INIT, and clears stage valid; the staged address/data do not need to be reset.
REQ-022 During reset: rd_data_a/b reflect the reset array contents, wr_pending=0.
REQ-023 A write staged when reset asserts is discarded (never commits).
REQ-024 First write capture occurs on the first rising edge with reset_n high.

Structure
REQ-025 Shared package holds: reg_addr_t (5-bit typedef), REG_ZERO=0, REG_SP=29, REG_RA=31, NUM_REGS=32.
REQ-026 One sub-module, reg_bank_fwd, implements the per-port read/forward selection of REQ-016 and is instantiated twice; the array and staging logic stay in reg_bank.

Verification
REQ-027 Reset then read addr 29 and 5 -> 32'h0000_00E3 and 0; wr_pending=0.
REQ-028 Write addr 8 = 32'hDEAD_BEEF at edge N, rd_addr_a=8 -> DEADBEEF after edge N (forwarded, wr_pending=1), still DEADBEEF after edge N+1 (committed, wr_pending=0).
REQ-029 Write addr 0 = 32'hFFFF_FFFF, read addr 0 on both ports -> 0 for all cycles; wr_pending=0.
REQ-030 Back-to-back writes addr 31 = 1 then 2, read addr 31 -> 1 after first edge, 2 after second and after all later edges.
REQ-031 Stage write addr 9 = 32'h1234_5678, assert reset_n low before the commit edge -> addr 9 reads 0 after reset, wr_pending=0.
REQ-032 Read addr 9 on port A and addr 10 on port B while writing addr 10 = 7 -> A unaffected, B = 7 after the capture edge.
